nibble_serial_alu_seq: RTL

- Multi-cycle 32-bit add/subtract sequencer for the area-reduced execute path.
- Drives the external 4-bit ripple adder one nibble per cycle, least significant nibble first, over 8 cycles, and chains the carry between nibbles.
- Collects the 4-bit sums into a 32-bit result and produces carry, signed overflow and zero flags.
- Uses valid/ready handshakes on both the operand side and the result side.

---
 rtl/nibble_serial_alu_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_alu_seq.sv
// Purpose : 32-bit add/subtract sequencer that feeds an external 4-bit ripple adder one nibble per cycle (LSN first).
// Latency : operands accepted at edge N, result/flags valid after edge N+NUM_NIBBLES; minimum issue interval NUM_NIBBLES+2.
// Backpr. : in_ready only in IDLE; result held in DONE until out_ready, then one handoff cycle back to IDLE.
// Ports   : clk/rst (sync, active-high); in_valid/in_ready/A/B/sub operand side;
//           out_valid/out_ready/Result/C_out/overflow/zero result side;
//           add_A/add_B/add_Invert_B/add_C_in to the adder, add_Sum/add_C_out back from it.
module nibble_serial_alu_seq #(
  parameter int NUM_NIBBLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*NUM_NIBBLES-1:0] A,
  input  logic [4*NUM_NIBBLES-1:0] B,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*NUM_NIBBLES-1:0] Result,
  output logic                     C_out,
  output logic                     overflow,
  output logic                     zero,
  output logic [3:0]               add_A,
  output logic [3:0]               add_B,
  output logic                     add_Invert_B,
  output logic                     add_C_in,
  input  logic [3:0]               add_Sum,
  input  logic                     add_C_out
);

  localparam int W  = 4 * NUM_NIBBLES;
  localparam int CW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_reg, b_reg;
  logic           sub_reg;
  logic           carry_reg;
  logic [CW-1:0]  cnt;
  logic           last;
  logic [W-1:0]   nib_mask;
  logic [W-1:0]   nib_data;
  logic [W-1:0]   result_nxt;

  assign last = (state == RUN) && (cnt == CW'(NUM_NIBBLES - 1));

  // Merge the adder's nibble into the current result; zero is taken from
  // this merged value so the flag reflects the final nibble as well.
  assign nib_mask   = W'(4'hF)    << {cnt, 2'b00};
  assign nib_data   = W'(add_Sum) << {cnt, 2'b00};
  assign result_nxt = (Result & ~nib_mask) | nib_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output logic; the adder interface is quiet outside RUN.
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    add_A        = 4'h0;
    add_B        = 4'h0;
    add_Invert_B = 1'b0;
    add_C_in     = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        add_A        = a_reg[{cnt, 2'b00} +: 4];
        add_B        = b_reg[{cnt, 2'b00} +: 4];
        add_Invert_B = sub_reg;
        add_C_in     = carry_reg;
      end
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, nibble accumulation and flag registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      Result    <= '0;
      C_out     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= A;
            b_reg     <= B;
            sub_reg   <= sub;
            carry_reg <= sub;  // subtract is A + ~B + 1
            cnt       <= '0;
          end
        end
        RUN: begin
          Result    <= result_nxt;
          carry_reg <= add_C_out;
          cnt       <= cnt + 1'b1;
          if (last) begin
            C_out    <= add_C_out;
            zero     <= (result_nxt == '0);
            // Operands of the effective addition share a sign but the sum's sign differs.
            overflow <= (a_reg[W-1] == (b_reg[W-1] ^ sub_reg)) && (add_Sum[3] != a_reg[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
